// File: rtl/pc_pkg.sv
// pc_pkg - shared types and defaults for the program-counter sequencer.
//   pc_state_e  : sequencer FSM states (IDLE, RUN, HALT)
//   D_DEFAULT   : default PC width (instruction memory depth 2^D)
//   AW_DEFAULT  : default branch-LUT index width
//   PC_RESET    : PC value on reset and at the start of every run
package pc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } pc_state_e;

  localparam int D_DEFAULT  = 10;
  localparam int AW_DEFAULT = 4;
  localparam int PC_RESET   = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_lut_if - branch-target LUT request/response bus.
//   lut_addr   : LUT index, driven by the sequencer (master)
//   lut_target : D-bit target, returned combinationally by the LUT (slave)
interface pc_lut_if #(
  parameter int D  = 10,
  parameter int AW = 4
);
  logic [AW-1:0] lut_addr;
  logic [D-1:0]  lut_target;

  modport master (output lut_addr, input lut_target);
  modport slave  (input lut_addr, output lut_target);
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// pc_next_calc - combinational next-PC selection.
//   pc_i         : current PC
//   branch_en_i  : branch taken
//   jump_rel_i   : 1 = target is a signed PC-relative offset, 0 = absolute
//   lut_target_i : LUT-supplied target/offset
//   pc_next_o    : next PC, modulo 2^D
module pc_next_calc #(
  parameter int D = 10
) (
  input  logic [D-1:0] pc_i,
  input  logic         branch_en_i,
  input  logic         jump_rel_i,
  input  logic [D-1:0] lut_target_i,
  output logic [D-1:0] pc_next_o
);

  // Offset and PC share the same width, so a plain D-bit add is the
  // two's-complement relative branch; the carry-out simply falls off.
  always_comb begin
    pc_next_o = pc_i + D'(1);
    if (branch_en_i) begin
      if (jump_rel_i) pc_next_o = pc_i + lut_target_i;
      else            pc_next_o = lut_target_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer - program-counter sequencer with run/halt control.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a run from PC 0 (from IDLE or HALT)
//   stall                 : hold PC and cycle counter
//   halt_req              : halt at the current PC
//   branch_en, jump_rel   : branch taken / relative vs absolute
//   lut_idx               : LUT index from the current instruction
//   lut                   : LUT bus (lut_addr out, lut_target in)
//   pc, running, done     : current PC, RUN decode, one-cycle halt pulse
//   cycle_cnt             : saturating count of non-stalled RUN cycles
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | fetching; PC advances unless stalled
// HALT  | run finished; pc/cycle_cnt held for readout
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int AW = AW_DEFAULT,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_en,
  input  logic          jump_rel,
  input  logic [AW-1:0] lut_idx,
  pc_lut_if.master      lut,
  output logic [D-1:0]  pc,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_HALT = S_HALT;

  logic [1:0]    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          done_q, done_d;
  logic [D-1:0]  pc_next;

  assign lut.lut_addr = lut_idx;

  pc_next_calc #(.D(D)) u_next (
    .pc_i         (pc_q),
    .branch_en_i  (branch_en),
    .jump_rel_i   (jump_rel),
    .lut_target_i (lut.lut_target),
    .pc_next_o    (pc_next)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
          cnt_d   = cnt_inc;
          done_d  = 1'b1;
        end else if (!stall) begin
          pc_d  = pc_next;
          cnt_d = cnt_inc;
        end
      end
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = D'(PC_RESET);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= D'(PC_RESET);
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign pc        = pc_q;
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer - directed plan plus randomized traffic against a
// behavioural model of the sequencer; LUT contents held in a bench array.
module tb_pc_sequencer;

  localparam int D      = 10;
  localparam int AW     = 4;
  localparam int CW     = 16;
  localparam int PC_MOD = 1 << D;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset, start, stall, halt_req, branch_en, jump_rel;
  logic [AW-1:0] lut_idx;
  logic [D-1:0]  pc;
  logic          running, done;
  logic [CW-1:0] cycle_cnt;
  logic [D-1:0]  lut_mem [16];

  pc_lut_if #(.D(D), .AW(AW)) lut_bus ();

  pc_sequencer #(.D(D), .AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .halt_req  (halt_req),
    .branch_en (branch_en),
    .jump_rel  (jump_rel),
    .lut_idx   (lut_idx),
    .lut       (lut_bus),
    .pc        (pc),
    .running   (running),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  always_comb lut_bus.lut_target = lut_mem[lut_bus.lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: mode is "idle", "run" or "halt"
  string m_mode = "idle";
  int    m_pc   = 0;
  int    m_cnt  = 0;
  int    m_done = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit stl, input bit hlt,
                      input bit br, input bit rel, input int idx);
    int tgt;
    @(negedge clk);
    reset = rst; start = st; stall = stl; halt_req = hlt;
    branch_en = br; jump_rel = rel; lut_idx = AW'(idx);
    #1;
    chk("lut_addr", int'(lut_bus.lut_addr), idx % 16);
    tgt = int'(lut_mem[idx % 16]);

    if (rst) begin
      m_mode = "idle"; m_pc = 0; m_cnt = 0; m_done = 0;
    end else if (m_mode == "run") begin
      m_done = 0;
      if (hlt) begin
        m_mode = "halt";
        m_done = 1;
        m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end else if (!stl) begin
        if (!br)      m_pc = (m_pc + 1) % PC_MOD;
        else if (rel) m_pc = (m_pc + tgt) % PC_MOD;
        else          m_pc = tgt;
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
    end else begin
      m_done = 0;
      if (st) begin
        m_mode = "run"; m_pc = 0; m_cnt = 0;
      end
    end

    @(posedge clk);
    #1;
    chk("pc", int'(pc), m_pc);
    chk("running", int'(running), (m_mode == "run") ? 1 : 0);
    chk("done", int'(done), m_done);
    chk("cycle_cnt", int'(cycle_cnt), m_cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    branch_en = 1'b0; jump_rel = 1'b0; lut_idx = '0;
    for (int i = 0; i < 16; i++) lut_mem[i] = '0;
    lut_mem[1] = 10'd10;
    lut_mem[2] = 10'd41;
    lut_mem[3] = 10'd1023;
    lut_mem[4] = 10'd10;
    lut_mem[5] = 10'd1020;
    lut_mem[6] = 10'd1023;
    lut_mem[7] = 10'd7;
    lut_mem[8] = 10'd9;
    lut_mem[9] = 10'd50;

    // args: rst, start, stall, halt, branch, rel, idx
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);                    // RUN, pc 0
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);        // pc 1..4, cnt 4
    step(0, 0, 0, 0, 1, 1, 3);                    // 4 + (-1) -> 3
    step(0, 0, 0, 0, 1, 0, 2);                    // abs -> 41
    step(0, 0, 0, 0, 1, 0, 1);                    // abs -> 10
    step(0, 0, 0, 0, 1, 0, 5);                    // abs -> 1020
    step(0, 0, 0, 0, 1, 1, 4);                    // 1020 + 10 -> 6
    step(0, 0, 0, 0, 1, 0, 6);                    // abs -> 1023
    step(0, 0, 0, 0, 0, 0, 0);                    // wrap -> 0
    step(0, 0, 0, 0, 1, 0, 7);                    // abs -> 7
    step(0, 0, 1, 0, 1, 0, 2);                    // stall beats branch
    step(0, 0, 0, 0, 1, 0, 8);                    // abs -> 9
    step(0, 0, 0, 1, 1, 0, 2);                    // halt beats branch
    step(0, 0, 1, 0, 1, 0, 2);                    // done drops, pc holds
    step(0, 1, 0, 0, 0, 0, 0);                    // restart, no done
    step(0, 0, 0, 0, 1, 0, 9);                    // abs -> 50
    step(1, 0, 0, 0, 0, 0, 0);                    // reset mid-run
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);                    // reset dominates start
    step(0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0)
        lut_mem[$urandom_range(0, 15)] = D'($urandom_range(0, PC_MOD - 1));
      step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)));
    end

    // long run to hit cycle-counter saturation
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < CNT_MAX + 5; n++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);                    // halt while saturated
    step(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
